// File: rtl/fir_mac_if.sv
// Handshake and datapath-control bundle between the FIR sequencer,
// the sample source and the buffer/coefficient-ROM/MAC datapath.
interface fir_mac_if #(
  parameter int InputWidth = 16,
  parameter int ADDR_W     = 6
);
  logic                  input_valid;
  logic [InputWidth-1:0] din;
  logic                  input_ready;
  logic                  buf_we;
  logic [ADDR_W-1:0]     buf_waddr;
  logic [InputWidth-1:0] buf_wdata;
  logic [ADDR_W-1:0]     buf_raddr;
  logic [ADDR_W-1:0]     coef_addr;
  logic                  mac_clr;
  logic                  mac_en;
  logic                  output_valid;
  logic                  busy;
  logic                  overrun;

  modport master (
    output input_valid, din,
    input  input_ready, buf_we, buf_waddr, buf_wdata,
    input  buf_raddr, coef_addr, mac_clr, mac_en,
    input  output_valid, busy, overrun
  );

  modport slave (
    input  input_valid, din,
    output input_ready, buf_we, buf_waddr, buf_wdata,
    output buf_raddr, coef_addr, mac_clr, mac_en,
    output output_valid, busy, overrun
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Serial FIR control sequencer: clears the sample buffer, then per frame
// writes one sample and walks all taps through the shared MAC.
module fir_mac_sequencer #(
  parameter int InputWidth = 16,
  parameter int TAPS       = 64,
  parameter int ADDR_W     = 6,
  parameter int RD_LAT     = 1,
  parameter int MAC_LAT    = 1
) (
  input logic      clk,
  input logic      rst,
  fir_mac_if.slave bus
);
  localparam int DrainN = RD_LAT + MAC_LAT;
  localparam logic [ADDR_W-1:0] KLast = ADDR_W'(TAPS - 1);
  localparam logic [ADDR_W-1:0] DLast = ADDR_W'(DrainN - 1);
  localparam logic [ADDR_W-1:0] One   = ADDR_W'(1);

  typedef enum logic [2:0] {
    CLEAR, IDLE, WRITE, ISSUE, DRAIN
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     k_q, k_d;
  logic [ADDR_W-1:0]     wp_q, wp_d;
  logic [InputWidth-1:0] din_q, din_d;
  logic                  overrun_q, overrun_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     waddr_q, waddr_d;
  logic [InputWidth-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0]     raddr_q, raddr_d;
  logic [ADDR_W-1:0]     coef_q, coef_d;
  logic                  issue_q, issue_d;
  logic                  first_q, first_d;
  logic                  oval_q, oval_d;
  logic [RD_LAT-1:0]     en_pipe_q;
  logic [RD_LAT-1:0]     clr_pipe_q;
  logic                  hs;

  assign hs = bus.input_valid & ready_q;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    wp_d      = wp_q;
    din_d     = din_q;
    overrun_d = overrun_q | (bus.input_valid & ~ready_q);
    ready_d   = 1'b0;
    we_d      = 1'b0;
    waddr_d   = '0;
    wdata_d   = '0;
    raddr_d   = '0;
    coef_d    = '0;
    issue_d   = 1'b0;
    first_d   = 1'b0;
    oval_d    = 1'b0;
    unique case (state_q)
      CLEAR: begin
        we_d    = 1'b1;
        waddr_d = k_q;
        k_d     = k_q + One;
        if (k_q == KLast) begin
          state_d = IDLE;
          k_d     = '0;
        end
      end
      IDLE: begin
        ready_d = ~hs;
        if (hs) begin
          din_d   = bus.din;
          state_d = WRITE;
        end
      end
      WRITE: begin
        we_d    = 1'b1;
        waddr_d = wp_q;
        wdata_d = din_q;
        k_d     = '0;
        state_d = ISSUE;
      end
      ISSUE: begin
        issue_d = 1'b1;
        first_d = (k_q == '0);
        raddr_d = wp_q - k_q;
        coef_d  = k_q;
        k_d     = k_q + One;
        if (k_q == KLast) begin
          state_d = DRAIN;
          k_d     = '0;
        end
      end
      DRAIN: begin
        k_d = k_q + One;
        // Last drain cycle: the next registered outputs mark IDLE entry.
        if (k_q == DLast) begin
          oval_d  = 1'b1;
          ready_d = 1'b1;
          wp_d    = wp_q + One;
          k_d     = '0;
          state_d = IDLE;
        end
      end
      default: state_d = CLEAR;
    endcase
    busy_d = ~ready_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      k_q        <= '0;
      wp_q       <= '0;
      din_q      <= '0;
      overrun_q  <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b1;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      raddr_q    <= '0;
      coef_q     <= '0;
      issue_q    <= 1'b0;
      first_q    <= 1'b0;
      oval_q     <= 1'b0;
      en_pipe_q  <= '0;
      clr_pipe_q <= '0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      wp_q          <= wp_d;
      din_q         <= din_d;
      overrun_q     <= overrun_d;
      ready_q       <= ready_d;
      busy_q        <= busy_d;
      we_q          <= we_d;
      waddr_q       <= waddr_d;
      wdata_q       <= wdata_d;
      raddr_q       <= raddr_d;
      coef_q        <= coef_d;
      issue_q       <= issue_d;
      first_q       <= first_d;
      oval_q        <= oval_d;
      en_pipe_q[0]  <= issue_q;
      clr_pipe_q[0] <= first_q;
      for (int i = 1; i < RD_LAT; i++) begin
        en_pipe_q[i]  <= en_pipe_q[i-1];
        clr_pipe_q[i] <= clr_pipe_q[i-1];
      end
    end
  end

  assign bus.input_ready  = ready_q;
  assign bus.busy         = busy_q;
  assign bus.overrun      = overrun_q;
  assign bus.buf_we       = we_q;
  assign bus.buf_waddr    = waddr_q;
  assign bus.buf_wdata    = wdata_q;
  assign bus.buf_raddr    = raddr_q;
  assign bus.coef_addr    = coef_q;
  assign bus.mac_en       = en_pipe_q[RD_LAT-1];
  assign bus.mac_clr      = clr_pipe_q[RD_LAT-1];
  assign bus.output_valid = oval_q;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: models buffer, ROM h[k]=k and MAC,
// and scores each FIR output against a reference built from accepted samples.
module tb_fir_mac_sequencer;
  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_fail;
  int   n_ov;

  fir_mac_if #(.InputWidth(16), .ADDR_W(6)) bus ();

  fir_mac_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Datapath model: buffer RAM, coefficient ROM h[k]=k, MAC.
  logic [15:0] mem [64];
  logic [15:0] x_q;
  logic [5:0]  h_q;
  logic [37:0] acc;

  always @(posedge clk) begin
    if (bus.buf_we) mem[bus.buf_waddr] <= bus.buf_wdata;
    x_q <= mem[bus.buf_raddr];
    h_q <= bus.coef_addr;
    if (bus.mac_en)
      acc <= (bus.mac_clr ? 38'd0 : acc) + 38'(x_q) * 38'(h_q);
  end

  // Scoreboard: reference FIR over accepted sample history.
  logic [15:0] hist [64];
  logic [37:0] exp_q [$];
  int          t_q [$];
  int          acc_log [$];
  int          wp_m;
  int          wpend;
  logic [5:0]  wexp_a;
  logic [15:0] wexp_d;
  logic [37:0] last_out;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      t_q.delete();
      wp_m  = 0;
      wpend = 0;
      for (int i = 0; i < 64; i++) hist[i] = '0;
    end else begin
      if (wpend != 0) begin
        wpend--;
        if (wpend == 0) begin
          chk("wr_we", bus.buf_we, 1);
          chk("wr_addr", bus.buf_waddr, wexp_a);
          chk("wr_data", bus.buf_wdata, wexp_d);
        end
      end
      if (bus.input_valid && bus.input_ready) begin
        logic [37:0] s;
        hist[wp_m] = bus.din;
        s = '0;
        for (int k = 0; k < 64; k++)
          s += 38'(k) * 38'(hist[(wp_m - k + 64) % 64]);
        exp_q.push_back(s);
        t_q.push_back(cyc + 1);
        acc_log.push_back(cyc + 1);
        wexp_a = 6'(wp_m);
        wexp_d = bus.din;
        wpend  = 2;
        wp_m   = (wp_m + 1) % 64;
      end
      if (bus.output_valid) begin
        n_ov++;
        chk("ov_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          logic [37:0] e;
          int t;
          e = exp_q.pop_front();
          t = t_q.pop_front();
          chk("fir_out", acc, e);
          chk("latency", cyc - t, 67);
          last_out = acc;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send(input logic [15:0] d);
    int n = 0;
    while (!bus.input_ready && n < 300) begin
      @(posedge clk);
      #1 n++;
    end
    chk("send_ready", bus.input_ready, 1);
    bus.input_valid = 1'b1;
    bus.din = d;
    @(posedge clk);
    #1 bus.input_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1 n++;
    end
    chk("drain_done", exp_q.size(), 0);
  endtask

  task automatic wait_coef(input logic [5:0] c);
    int n = 0;
    while (!(bus.busy && bus.coef_addr == c) && n < 300) begin
      @(posedge clk);
      #1 n++;
    end
    chk("coef_reached", bus.coef_addr, c);
  endtask

  initial begin
    int base;
    int ov0;
    n_chk = 0;
    n_fail = 0;
    n_ov = 0;
    last_out = '0;
    bus.input_valid = 1'b0;
    bus.din = '0;

    // Reset state and buffer clear sweep.
    do_reset();
    chk("rst_busy", bus.busy, 1);
    chk("rst_ready", bus.input_ready, 0);
    chk("rst_we", bus.buf_we, 0);
    chk("rst_ov", bus.output_valid, 0);
    chk("rst_mac_en", bus.mac_en, 0);
    chk("rst_overrun", bus.overrun, 0);
    for (int c = 1; c <= 70; c++) begin
      @(posedge clk);
      #1 chk("clr_we", bus.buf_we, c <= 64);
      if (c <= 64) begin
        chk("clr_addr", bus.buf_waddr, c - 1);
        chk("clr_data", bus.buf_wdata, 0);
      end
      chk("clr_ready", bus.input_ready, c >= 65);
      chk("clr_busy", bus.busy, c < 65);
    end

    // First sample: write address 0, tap address walk, MAC flags.
    send(16'h0001);
    @(posedge clk);
    #1 chk("f0_we", bus.buf_we, 1);
    chk("f0_waddr", bus.buf_waddr, 0);
    chk("f0_wdata", bus.buf_wdata, 1);
    for (int k = 0; k < 64; k++) begin
      @(posedge clk);
      #1 chk("f0_raddr", bus.buf_raddr, (64 - k) % 64);
      chk("f0_coef", bus.coef_addr, k);
      chk("f0_no_we", bus.buf_we, 0);
      if (k == 1) begin
        chk("f0_clr", bus.mac_clr, 1);
        chk("f0_en", bus.mac_en, 1);
      end
      if (k == 2) chk("f0_clr_off", bus.mac_clr, 0);
    end
    wait_idle();
    chk("impulse_h0", last_out, 0);

    // Impulse response through 63 zero samples, then pointer wrap.
    for (int n = 1; n < 64; n++) send(16'h0000);
    wait_idle();
    chk("impulse_h63", last_out, 63);
    send(16'h0000);
    @(posedge clk);
    #1 chk("wrap_waddr", bus.buf_waddr, 0);
    wait_idle();

    // input_valid held high: accept spacing.
    base = acc_log.size();
    bus.input_valid = 1'b1;
    for (int n = 0; n < 400 && acc_log.size() < base + 3; n++) begin
      bus.din = 16'($urandom);
      @(posedge clk);
      #1;
    end
    bus.input_valid = 1'b0;
    chk("hold_accepts", acc_log.size() >= base + 3, 1);
    if (acc_log.size() >= base + 3) begin
      chk("hold_gap1", acc_log[base+1] - acc_log[base], 68);
      chk("hold_gap2", acc_log[base+2] - acc_log[base+1], 68);
    end
    wait_idle();

    // Pulse during ISSUE: dropped sample, sticky overrun.
    do_reset();
    send(16'h1234);
    chk("ovr_clear", bus.overrun, 0);
    wait_coef(6'd10);
    bus.input_valid = 1'b1;
    bus.din = 16'hffff;
    @(posedge clk);
    #1 bus.input_valid = 1'b0;
    @(posedge clk);
    #1 chk("ovr_set", bus.overrun, 1);
    wait_idle();
    chk("ovr_sticky", bus.overrun, 1);
    send(16'h0002);
    wait_idle();
    chk("ovr_still", bus.overrun, 1);

    // Reset mid-ISSUE: frame abandoned, pointer back to 0.
    send(16'h0055);
    wait_coef(6'd30);
    ov0 = n_ov;
    do_reset();
    chk("mid_rst_en", bus.mac_en, 0);
    chk("mid_rst_busy", bus.busy, 1);
    chk("mid_rst_ov", bus.output_valid, 0);
    chk("mid_rst_ovr", bus.overrun, 0);
    repeat (140) @(posedge clk);
    #1 chk("mid_rst_no_out", n_ov, ov0);
    send(16'h0007);
    @(posedge clk);
    #1 chk("mid_rst_we", bus.buf_we, 1);
    chk("mid_rst_wp0", bus.buf_waddr, 0);
    wait_idle();
    chk("mid_rst_out", last_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
